// File: rtl/muldiv_div_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : muldiv_div_controller_pkg                                |
// | Description : Shared ALU op codes, widths, result-cache record and     |
// |               small helpers for the RV32M divide sequencer.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package muldiv_div_controller_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    // ALU op codes shared with the EX-stage ALU
    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_SUB  = 5'h01;
    localparam logic [4:0] ALU_AND  = 5'h02;
    localparam logic [4:0] ALU_OR   = 5'h03;
    localparam logic [4:0] ALU_XOR  = 5'h04;
    localparam logic [4:0] ALU_SLL  = 5'h05;
    localparam logic [4:0] ALU_SRL  = 5'h06;
    localparam logic [4:0] ALU_SRA  = 5'h07;
    localparam logic [4:0] ALU_SLT  = 5'h08;
    localparam logic [4:0] ALU_SLTU = 5'h09;
    localparam logic [4:0] ALU_DIV  = 5'h10;
    localparam logic [4:0] ALU_DIVU = 5'h11;
    localparam logic [4:0] ALU_REM  = 5'h12;
    localparam logic [4:0] ALU_REMU = 5'h13;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // One-entry record of the last completed long divide
    typedef struct packed {
        logic            valid;
        logic            is_signed;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] quot;
        logic [XLEN-1:0] rem;
    } div_cache_t;

    function automatic logic is_div_op(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_DIVU) ||
               (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_controller_div_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : muldiv_div_controller_div_step                           |
// | Description : One combinational restoring-division step.               |
// |   i_acc     : {rem, quot} before the step                              |
// |   i_divisor : unsigned divisor                                         |
// |   o_acc     : {rem, quot} after shift-left and trial subtract          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module muldiv_div_controller_div_step
    import muldiv_div_controller_pkg::*;
(
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_divisor,
    output logic [2*XLEN-1:0] o_acc
);

    // The shifted partial remainder needs one extra bit: it can reach
    // 2*divisor-1, which overflows XLEN bits for large divisors.
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN-1:0] w_quot_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_fits;

    assign w_rem_shift  = i_acc[2*XLEN-1:XLEN-1];
    assign w_quot_shift = {i_acc[XLEN-2:0], 1'b0};
    assign w_fits       = (w_rem_shift >= {1'b0, i_divisor});
    // When the subtract succeeds the difference is below the divisor, so
    // truncating to XLEN bits is exact.
    assign w_diff       = w_rem_shift[XLEN-1:0] - i_divisor;

    assign o_acc = w_fits ? {w_diff, w_quot_shift | XLEN'(1)}
                          : {w_rem_shift[XLEN-1:0], w_quot_shift};

endmodule
`default_nettype wire

// File: rtl/muldiv_div_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : muldiv_div_controller                                    |
// | Description : Multi-cycle DIV/DIVU/REM/REMU sequencer beside the ALU.  |
// |   CLK, RESET  : clock, synchronous active-high reset                   |
// |   START       : EX stage presents an op; SELECT = ALU op code          |
// |   DATA1/DATA2 : dividend / divisor                                     |
// |   FLUSH       : abort the operation in flight                          |
// |   BUSY        : stall request; DONE : one-cycle RESULT-valid pulse     |
// |   RESULT      : quotient or remainder, held between operations         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module muldiv_div_controller
    import muldiv_div_controller_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              want_rem_q, want_rem_d;
    logic              signed_q, signed_d;
    div_cache_t        cache_q, cache_d;

    logic              w_is_signed_op;
    logic              w_is_rem_op;
    logic              w_accept;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_cache_hit;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_fix_quot;
    logic [XLEN-1:0]   w_fix_rem;
    logic [2*XLEN-1:0] w_step_acc;

    muldiv_div_controller_div_step u_div_step (
        .i_acc     (acc_q),
        .i_divisor (dvsr_q),
        .o_acc     (w_step_acc)
    );

    assign w_is_signed_op = (SELECT == ALU_DIV) || (SELECT == ALU_REM);
    assign w_is_rem_op    = (SELECT == ALU_REM) || (SELECT == ALU_REMU);
    assign w_accept       = START && is_div_op(SELECT) && !FLUSH &&
                            ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_div_zero     = (DATA2 == '0);
    assign w_overflow     = w_is_signed_op && (DATA1 == INT_MIN) && (DATA2 == ALL_ONES);
    assign w_cache_hit    = cache_q.valid && (cache_q.op1 == DATA1) &&
                            (cache_q.op2 == DATA2) && (cache_q.is_signed == w_is_signed_op);

    assign w_abs1 = (w_is_signed_op && DATA1[XLEN-1]) ? negate(DATA1) : DATA1;
    assign w_abs2 = (w_is_signed_op && DATA2[XLEN-1]) ? negate(DATA2) : DATA2;

    assign w_fix_quot = neg_quot_q ? negate(acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
    assign w_fix_rem  = neg_rem_q  ? negate(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvsr_d     = dvsr_q;
        result_d   = result_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        want_rem_d = want_rem_q;
        signed_d   = signed_q;
        cache_d    = cache_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    if (w_div_zero) begin
                        result_d = w_is_rem_op ? DATA1 : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (w_overflow) begin
                        result_d = w_is_rem_op ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else if (w_cache_hit) begin
                        result_d = w_is_rem_op ? cache_q.rem : cache_q.quot;
                        state_d  = S_DONE;
                    end else begin
                        state_d    = S_ITER;
                        cnt_d      = '0;
                        acc_d      = {{XLEN{1'b0}}, w_abs1};
                        dvsr_d     = w_abs2;
                        neg_quot_d = w_is_signed_op && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                        neg_rem_d  = w_is_signed_op && DATA1[XLEN-1];
                        want_rem_d = w_is_rem_op;
                        signed_d   = w_is_signed_op;
                        op1_d      = DATA1;
                        op2_d      = DATA2;
                        // The old entry may describe these very operands
                        // mid-rewrite, so drop it until FIXUP refills it.
                        cache_d.valid = 1'b0;
                    end
                end
            end
            S_ITER: begin
                acc_d = w_step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = want_rem_q ? w_fix_rem : w_fix_quot;
                cache_d  = '{valid: 1'b1, is_signed: signed_q, op1: op1_q,
                             op2: op2_q, quot: w_fix_quot, rem: w_fix_rem};
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a FIXUP that would
        // otherwise publish a result.
        if (FLUSH) begin
            state_d       = S_IDLE;
            result_d      = result_q;
            cache_d.valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvsr_q     <= '0;
            result_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            signed_q   <= 1'b0;
            cache_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            result_q   <= result_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            want_rem_q <= want_rem_d;
            signed_q   <= signed_d;
            cache_q    <= cache_d;
        end
    end

    assign BUSY   = (state_q == S_ITER) || (state_q == S_FIXUP) || w_accept;
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_div_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_muldiv_div_controller                                 |
// | Description : Self-checking bench: directed scenarios plus random      |
// |               traffic compared every cycle against an arithmetic       |
// |               latency/result model of the divide sequencer.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_muldiv_div_controller;
    import muldiv_div_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [4:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_div_controller dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .SELECT (sel),
        .DATA1  (d1),
        .DATA2  (d2),
        .FLUSH  (flush),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result)
    );

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    bit chk_en = 1'b0;

    // Model: cycles still to wait before the DONE cycle, pending answer,
    // current expected DONE/RESULT, and the one-entry cache contents.
    int          m_pending = 0;
    logic [31:0] m_pend_res = '0;
    bit          m_done = 1'b0;
    logic [31:0] m_result = '0;
    bit          c_valid = 1'b0;
    bit          c_signed = 1'b0;
    logic [31:0] c_op1 = '0;
    logic [31:0] c_op2 = '0;
    bit          pf_signed = 1'b0;
    logic [31:0] pf_op1 = '0;
    logic [31:0] pf_op2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V division semantics from plain arithmetic
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic bit op_is_div(input logic [4:0] s);
        return s == ALU_DIV || s == ALU_DIVU || s == ALU_REM || s == ALU_REMU;
    endfunction

    // Compare this cycle's outputs, then advance the model across the edge.
    task automatic step_model();
        bit          acc;
        bit          sgn;
        bit          hit;
        bit          fast;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] res;
        acc = start && op_is_div(sel) && (m_pending == 0) && !flush;
        chk("busy", 32'(busy), 32'((m_pending > 0) || acc));
        chk("done", 32'(done), 32'(m_done));
        chk("result", result, m_result);
        busy_cnt += int'(busy);

        if (rst) begin
            m_pending = 0;
            m_done    = 1'b0;
            m_result  = '0;
            c_valid   = 1'b0;
        end else if (flush) begin
            m_pending = 0;
            m_done    = 1'b0;
            c_valid   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pending > 0) begin
                m_pending--;
                if (m_pending == 0) begin
                    m_done   = 1'b1;
                    m_result = m_pend_res;
                    c_valid  = 1'b1;
                    c_signed = pf_signed;
                    c_op1    = pf_op1;
                    c_op2    = pf_op2;
                end
            end else if (acc) begin
                sgn = (sel == ALU_DIV) || (sel == ALU_REM);
                ref_div(sgn, d1, d2, q, r);
                res  = (sel == ALU_REM || sel == ALU_REMU) ? r : q;
                hit  = c_valid && c_op1 == d1 && c_op2 == d2 && c_signed == sgn;
                fast = (d2 == 32'd0) || (sgn && d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) || hit;
                if (fast) begin
                    m_done   = 1'b1;
                    m_result = res;
                end else begin
                    c_valid    = 1'b0;
                    m_pending  = 33;
                    m_pend_res = res;
                    pf_signed  = sgn;
                    pf_op1     = d1;
                    pf_op2     = d2;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) step_model();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle, wait (bounded) for DONE, return latency.
    task automatic run_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start = 1'b1;
        sel   = s;
        d1    = a;
        d2    = b;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no DONE after %0d cycles, required DONE", lat);
        end
    endtask

    logic [4:0]  sel_pool [6];
    logic [31:0] val_pool [8];

    initial begin
        int          lat;
        int          dones;
        logic [31:0] q;
        logic [31:0] r;

        sel_pool = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ADD, ALU_SUB};
        val_pool = '{32'd0, 32'd1, 32'd2, 32'd7, 32'h64, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        rst = 1'b1; start = 1'b0; flush = 1'b0; sel = ALU_ADD; d1 = '0; d2 = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);

        // Pin the arithmetic model with hand-computed answers
        ref_div(1'b0, 32'h64, 32'd7, q, r);
        chk("pin_divu_q", q, 32'h0000_000E);
        chk("pin_remu_r", r, 32'h0000_0002);
        ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, q, r);
        chk("pin_div_q", q, 32'hFFFF_FFFD);
        chk("pin_rem_r", r, 32'hFFFF_FFFF);

        // 1: long unsigned divide
        busy_cnt = 0;
        run_op(ALU_DIVU, 32'h64, 32'd7, lat);
        chk("t1_latency", 32'(lat), 32'd34);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd34);
        chk("t1_result", result, 32'h0000_000E);

        // 2: signed divide then back-to-back REM hitting the cache
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        chk("t2_div_latency", 32'(lat), 32'd34);
        chk("t2_div_result", result, 32'hFFFF_FFFD);
        run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, lat);
        chk("t2_rem_latency", 32'(lat), 32'd1);
        chk("t2_rem_result", result, 32'hFFFF_FFFF);

        // 3: divide by zero
        run_op(ALU_DIVU, 32'h1234, 32'd0, lat);
        chk("t3_divu_latency", 32'(lat), 32'd1);
        chk("t3_divu_result", result, 32'hFFFF_FFFF);
        run_op(ALU_REMU, 32'h1234, 32'd0, lat);
        chk("t3_remu_latency", 32'(lat), 32'd1);
        chk("t3_remu_result", result, 32'h0000_1234);

        // 4: signed overflow
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("t4_div_latency", 32'(lat), 32'd1);
        chk("t4_div_result", result, 32'h8000_0000);
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("t4_rem_latency", 32'(lat), 32'd1);
        chk("t4_rem_result", result, 32'h0000_0000);

        // 5a: flush in cycle 10 aborts and drops the cache
        start = 1'b1; sel = ALU_DIVU; d1 = 32'h64; d2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_busy_after_flush", 32'(busy), 32'd0);
        dones = 0;
        repeat (30) begin
            dones += int'(done);
            tick();
        end
        chk("t5_no_done", 32'(dones), 32'd0);
        run_op(ALU_REMU, 32'h64, 32'd7, lat);
        chk("t5_remu_latency", 32'(lat), 32'd34);
        chk("t5_remu_result", result, 32'h0000_0002);

        // 5b: reset in cycle 10 (idle flush first so the op misses the cache)
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b1; sel = ALU_DIVU; d1 = 32'h64; d2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_reset_busy", 32'(busy), 32'd0);
        chk("t5_reset_result", result, 32'd0);
        repeat (5) tick();
        run_op(ALU_REMU, 32'h64, 32'd7, lat);
        chk("t5r_remu_latency", 32'(lat), 32'd34);
        chk("t5r_remu_result", result, 32'h0000_0002);

        // 6: non-divide op is ignored
        tick();
        start = 1'b1; sel = ALU_ADD; d1 = 32'd5; d2 = 32'd3;
        dones = 0;
        repeat (4) begin
            tick();
            dones += int'(done);
        end
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_done", 32'(dones), 32'd0);
        chk("t6_result_held", result, 32'h0000_0002);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 1) == 1);
            sel   = sel_pool[$urandom_range(0, 5)];
            d1    = ($urandom_range(0, 4) == 0) ? $urandom : val_pool[$urandom_range(0, 7)];
            d2    = ($urandom_range(0, 4) == 0) ? $urandom : val_pool[$urandom_range(0, 7)];
            tick();
        end
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
